// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator in the master clock domain.
// Each channel emits a one-cycle clk_en pulse every DIV master clocks at a
// programmable phase, plus an active-high reset held for RST_EN_LENGTH of its
// own enable ticks. run/step/resync give free-run, single-step and realign.
module clk_en_gen #(
  parameter int unsigned                       NUM_CH        = 2,
  parameter int unsigned                       DIV_WIDTH     = 5,
  parameter logic [NUM_CH*DIV_WIDTH-1:0]       CH_DIV        = {5'd4, 5'd12},
  parameter logic [NUM_CH*DIV_WIDTH-1:0]       CH_PHASE      = {5'd0, 5'd0},
  parameter int unsigned                       RST_EN_LENGTH = 4
) (
  input  logic              clk_mst,
  input  logic              rst_mst_n,
  input  logic              run,
  input  logic              step,
  input  logic              resync,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] rst_en,
  output logic              coinc
);

  // Packed view whose element i lines up with field [i*DIV_WIDTH +: DIV_WIDTH].
  localparam logic [NUM_CH-1:0][DIV_WIDTH-1:0] DIV_ARR   = CH_DIV;
  localparam logic [NUM_CH-1:0][DIV_WIDTH-1:0] PHASE_ARR = CH_PHASE;
  localparam logic [3:0]                       TICK_LAST = 4'(RST_EN_LENGTH - 1);

  logic [NUM_CH-1:0][DIV_WIDTH-1:0] cnt_q,    cnt_d;
  logic [NUM_CH-1:0][3:0]           tick_q,   tick_d;
  logic [NUM_CH-1:0]                clk_en_q, clk_en_d;
  logic [NUM_CH-1:0]                rst_en_q, rst_en_d;
  logic                             coinc_q,  coinc_d;
  logic                             advance;

  // step is only meaningful while run is low; OR-ing covers both cases.
  assign advance = run | step;

  // Next-state for every channel counter, enable pulse and reset stretcher.
  always_comb begin
    cnt_d    = cnt_q;
    tick_d   = tick_q;
    clk_en_d = '0;
    rst_en_d = rst_en_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (resync) begin
        cnt_d[i] = PHASE_ARR[i];
      end else if (advance) begin
        clk_en_d[i] = (cnt_q[i] == '0);
        cnt_d[i]    = (cnt_q[i] == '0) ? DIV_ARR[i] - 1'b1 : cnt_q[i] - 1'b1;
      end
      // Stretcher counts ticks seen by enable-gated logic, then releases.
      if (clk_en_q[i] && rst_en_q[i]) begin
        tick_d[i] = tick_q[i] + 4'd1;
        if (tick_q[i] == TICK_LAST) begin
          rst_en_d[i] = 1'b0;
        end
      end
    end
    coinc_d = &clk_en_d;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_mst or negedge rst_mst_n) begin
    if (!rst_mst_n) begin
      cnt_q    <= PHASE_ARR;
      tick_q   <= '0;
      clk_en_q <= '0;
      rst_en_q <= '1;
      coinc_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      clk_en_q <= clk_en_d;
      rst_en_q <= rst_en_d;
      coinc_q  <= coinc_d;
    end
  end

  assign clk_en = clk_en_q;
  assign rst_en = rst_en_q;
  assign coinc  = coinc_q;

  // Elaboration-time parameter sanity checks.
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("clk_en_gen: NUM_CH must be 1..8");
  end
  if (RST_EN_LENGTH < 1 || RST_EN_LENGTH > 15) begin : g_bad_rst_len
    $error("clk_en_gen: RST_EN_LENGTH must be 1..15");
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chk
    if (DIV_ARR[g] == '0) begin : g_bad_div
      $error("clk_en_gen: CH_DIV of channel %0d is zero", g);
    end
    if (PHASE_ARR[g] >= DIV_ARR[g]) begin : g_bad_phase
      $error("clk_en_gen: CH_PHASE of channel %0d not below CH_DIV", g);
    end
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: three instances (default, ch1 phase 2,
// three channels with a /1 channel) share the clock and control inputs.
module tb_clk_en_gen;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       resync;

  logic [1:0] en_a, rst_a;
  logic       co_a;
  logic [1:0] en_b, rst_b;
  logic       co_b;
  logic [2:0] en_c, rst_c;
  logic       co_c;

  int vectors;
  int miscompares;

  clk_en_gen #(
    .NUM_CH(2), .DIV_WIDTH(5), .CH_DIV({5'd4, 5'd12}),
    .CH_PHASE({5'd0, 5'd0}), .RST_EN_LENGTH(4)
  ) u_a (
    .clk_mst(clk), .rst_mst_n(rst_n), .run(run), .step(step), .resync(resync),
    .clk_en(en_a), .rst_en(rst_a), .coinc(co_a)
  );

  clk_en_gen #(
    .NUM_CH(2), .DIV_WIDTH(5), .CH_DIV({5'd4, 5'd12}),
    .CH_PHASE({5'd2, 5'd0}), .RST_EN_LENGTH(4)
  ) u_b (
    .clk_mst(clk), .rst_mst_n(rst_n), .run(run), .step(step), .resync(resync),
    .clk_en(en_b), .rst_en(rst_b), .coinc(co_b)
  );

  clk_en_gen #(
    .NUM_CH(3), .DIV_WIDTH(5), .CH_DIV({5'd1, 5'd4, 5'd12}),
    .CH_PHASE({5'd0, 5'd0, 5'd0}), .RST_EN_LENGTH(4)
  ) u_c (
    .clk_mst(clk), .rst_mst_n(rst_n), .run(run), .step(step), .resync(resync),
    .clk_en(en_c), .rst_en(rst_c), .coinc(co_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse expected on the n-th advance since (re)load; n=0 means no advance.
  function automatic logic exp_en(input int n, input int div, input int ph);
    if (n < 1)       return 1'b0;
    if (n - 1 < ph)  return 1'b0;
    return ((n - 1 - ph) % div) == 0;
  endfunction

  task automatic chk(input string tag, input int c, input logic [2:0] obs,
                     input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_en_a"},  0, {1'b0, en_a},  3'b000);
    chk({tag, "_rst_a"}, 0, {1'b0, rst_a}, 3'b011);
    chk({tag, "_co_a"},  0, {2'b0, co_a},  3'b000);
    chk({tag, "_en_b"},  0, {1'b0, en_b},  3'b000);
    chk({tag, "_rst_b"}, 0, {1'b0, rst_b}, 3'b011);
    chk({tag, "_co_b"},  0, {2'b0, co_b},  3'b000);
    chk({tag, "_en_c"},  0, en_c,          3'b000);
    chk({tag, "_rst_c"}, 0, rst_c,         3'b111);
    chk({tag, "_co_c"},  0, {2'b0, co_c},  3'b000);
  endtask

  // Enables and coincidence of all three instances after n advances.
  task automatic check_en(input string tag, input int c, input int n);
    logic a0, a1, b1, c2;
    a0 = exp_en(n, 12, 0);
    a1 = exp_en(n, 4, 0);
    b1 = exp_en(n, 4, 2);
    c2 = exp_en(n, 1, 0);
    chk({tag, "_en_a"}, c, {1'b0, en_a}, {1'b0, a1, a0});
    chk({tag, "_co_a"}, c, {2'b0, co_a}, {2'b0, a0 & a1});
    chk({tag, "_en_b"}, c, {1'b0, en_b}, {1'b0, b1, a0});
    chk({tag, "_co_b"}, c, {2'b0, co_b}, {2'b0, a0 & b1});
    chk({tag, "_en_c"}, c, en_c, {c2, a1, a0});
    chk({tag, "_co_c"}, c, {2'b0, co_c}, {2'b0, a0 & a1 & c2});
  endtask

  // rst_en fall cycles for free-running from reset: ch0 /12 -> 38,
  // ch1 /4 -> 14, ch1 /4 phase 2 -> 16, ch2 /1 -> 5.
  task automatic check_rst_free(input string tag, input int c);
    chk({tag, "_rst_a"}, c, {1'b0, rst_a}, {1'b0, c < 14, c < 38});
    chk({tag, "_rst_b"}, c, {1'b0, rst_b}, {1'b0, c < 16, c < 38});
    chk({tag, "_rst_c"}, c, rst_c, {c < 5, c < 14, c < 38});
  endtask

  // Reset pulse released at a falling edge; next rising edge is cycle 1.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Free-run for ncyc cycles; resync driven in cycle rs_at (0 = never).
  // step toggles throughout and must have no effect while run=1.
  task automatic run_free(input string tag, input int ncyc, input int rs_at);
    int n;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (rs_at == 0 || c <= rs_at) n = c;
      else if (c == rs_at + 1)      n = 0;
      else                          n = c - rs_at - 1;
      check_en(tag, c, n);
      check_rst_free(tag, c);
      resync = (c == rs_at);
      step   = (c % 5 == 0);
    end
    resync = 1'b0;
    step   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    run    = 1'b0;
    step   = 1'b0;
    resync = 1'b0;

    #12;
    check_reset("por");

    // Free-run up to the coincident pulse in cycle 49, then async reset.
    run = 1'b1;
    do_reset();
    run_free("free49", 49, 0);
    #2 rst_n = 1'b0;
    #1 check_reset("async");

    // After release the sequence repeats; resync in cycle 50, step ignored.
    @(negedge clk);
    rst_n = 1'b1;
    run_free("free200", 200, 50);

    // run low for cycles 7..16: no pulses, phase preserved afterwards.
    run = 1'b1;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      int n;
      @(negedge clk);
      if (c <= 6)       n = c;
      else if (c <= 16) n = 0;
      else              n = c - 10;
      check_en("gap", c, n);
      run = !(c >= 6 && c < 16);
    end
    run = 1'b1;

    // Single-step: 12 one-cycle step pulses in cycles 2,5,..,35 with run=0.
    run = 1'b0;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      int n;
      @(negedge clk);
      if (c >= 3 && (c - 3) % 3 == 0 && (c - 3) / 3 < 12) n = (c - 3) / 3 + 1;
      else                                                n = 0;
      check_en("step", c, n);
      chk("step_rst_a", c, {1'b0, rst_a}, 3'b011);
      chk("step_rst_b", c, {1'b0, rst_b}, 3'b011);
      chk("step_rst_c", c, rst_c, {c < 13, 2'b11});
      step = (c >= 2 && (c - 2) % 3 == 0 && (c - 2) / 3 < 12);
    end
    step = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised multi-channel clock-enable generator in the master clock domain.
- Each channel produces a one-cycle `clk_en` pulse every DIV master clocks, with a programmable phase offset.
- Each channel also produces a reset held for a fixed number of its own enable ticks.
- Adds run/step/resync control and a coincidence output, for CPU/PPU enables and debug single-stepping.

Parameters:
- NUM_CH, 2, number of enable channels (1..8).
- DIV_WIDTH, 5, width of each divide/phase field.
- CH_DIV, {5'd4,5'd12}, packed NUM_CH*DIV_WIDTH divide ratios; channel i at [i*DIV_WIDTH +: DIV_WIDTH]; legal 1..2^DIV_WIDTH-1; default ch0=CPU /12, ch1=PPU /4.
- CH_PHASE, {5'd0,5'd0}, packed phase offsets, same layout; legal 0..CH_DIV_i-1.
- RST_EN_LENGTH, 4, number of channel enable ticks during which rst_en_i is held asserted (1..15).

Ports:
- clk_mst  in  1  master clock
- rst_mst_n  in  1  asynchronous, active-low reset
- run  in  1  1 = free-running; 0 = counters frozen
- step  in  1  single-cycle advance pulse; honoured only while run=0
- resync  in  1  synchronous pulse; reloads all channel counters to their phases
- clk_en  out  NUM_CH  per-channel enable pulses, registered
- rst_en  out  NUM_CH  per-channel active-high reset, synchronous to that channel's enable
- coinc  out  1  high in cycles where every clk_en bit is high, registered

Behaviour:
- Reset (rst_mst_n=0, asynchronous): cnt_i=CH_PHASE_i, clk_en=0, coinc=0, rst_en=all 1s, tick counters=0.
- Cycle numbering: edge/cycle 1 is the first rising edge with rst_mst_n=1; cycle k is the interval after edge k.
- advance = run | step.
- Per channel, each edge, in priority order:
  - resync=1: cnt_i <= CH_PHASE_i; clk_en_i <= 0.
  - Else if advance: clk_en_i <= (cnt_i==0); cnt_i <= (cnt_i==0) ? CH_DIV_i-1 : cnt_i-1.
  - Else: cnt_i holds; clk_en_i <= 0.
- Resulting timing: with run=1, the first clk_en_i pulse is in cycle CH_PHASE_i+1, then one pulse every CH_DIV_i cycles.
- CH_DIV_i=1: clk_en_i is continuously high while advance=1.
- coinc <= &(next clk_en) on the same edge, so coinc is cycle-aligned with clk_en. resync forces coinc to 0.
- rst_en_i, per-channel 4-bit tick counter:
  - On each edge where clk_en_i=1 and rst_en_i=1: increment the counter.
  - When the counter equals RST_EN_LENGTH-1 on such an edge: rst_en_i <= 0.
  - Net effect: logic gated by clk_en_i samples rst_en_i=1 on exactly RST_EN_LENGTH enable ticks, then 0.
  - rst_en_i stays 0 until the next rst_mst_n assertion; resync/run/step do not re-assert it.
- run=0 with step=1: exactly one advance occurs; step is ignored while run=1.
- Latency: counter state to clk_en is one register; no combinational path from inputs to outputs.
- Simultaneous resync and step/run: resync wins and the advance is lost.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously).
- Illegal parameters (DIV=0, PHASE>=DIV): flagged by a simulation-only elaboration $error.

Test Plan:
1. Defaults, run=1 from cycle 1:
   - clk_en[0] high in cycles 1,13,25,37,49.
   - clk_en[1] high in cycles 1,5,9,13.
   - coinc high in cycles 1,13,25.
   - rst_en[1] falls at cycle 14; rst_en[0] falls at cycle 38, so the 5th ch0 pulse (cycle 49) sees rst_en[0]=0.
2. run=1, deassert run in cycle 6, hold low 10 cycles, reassert:
   - No clk_en during the gap.
   - Both channels resume with phase preserved; the next ch1 pulse arrives 3 cycles after run returns.
3. run=0 after reset, 12 single-cycle step pulses spaced 3 cycles apart:
   - clk_en[0] pulses once, in the cycle after the 1st step.
   - clk_en[1] pulses after steps 1,5,9.
   - Steps issued while run=1 change nothing.
4. CH_PHASE ch1=2, run=1:
   - clk_en[1] in cycles 3,7,11,15; clk_en[0] in cycles 1,13.
   - coinc never asserts over 200 cycles.
   - resync in cycle 50 → both channels restart per phase offsets relative to cycle 51.
5. Assert rst_mst_n=0 asynchronously mid-pulse after rst_en has fallen:
   - clk_en=0, coinc=0 and rst_en=2'b11 without waiting for a clock edge.
   - After release, the scenario-1 sequence repeats exactly.
6. NUM_CH=3 with CH_DIV ch2=1, run=1:
   - clk_en[2] constantly high.
   - coinc matches clk_en[0]&clk_en[1].
   - rst_en[2] falls at cycle 5.
